// File: rtl/seq_divider_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_divider_pkg                                                 |
// | Brief    : State encodings and sizing helper shared by seq_divider.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package seq_divider_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] S_PREP_A = 3'd1;
    localparam logic [STATE_W-1:0] S_PREP_B = 3'd2;
    localparam logic [STATE_W-1:0] S_RUN    = 3'd3;
    localparam logic [STATE_W-1:0] S_FIX    = 3'd4;
    localparam logic [STATE_W-1:0] S_DONE   = 3'd5;

    // Iteration counter only has to reach N-1.
    function automatic int count_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider_add_sub.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_divider_add_sub                                             |
// | Brief    : Shared W-bit adder/subtractor; cout=1 means no borrow on sub.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seq_divider_add_sub #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         addn_sub,
    output logic [W-1:0] result,
    output logic         cout
);

    assign {cout, result} = {1'b0, a}
                          + {1'b0, b ^ {W{addn_sub}}}
                          + {{W{1'b0}}, addn_sub};

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_divider                                                     |
// | Brief    : Multi-cycle restoring divider, one quotient bit per clock.      |
// |            SEQ_DIVIDER_SIGNED_EN enables two's-complement operands.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int            CW     = count_width(N);
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);

    logic [STATE_W-1:0] r_state;
    logic [N-1:0]       r_r;
    logic [N-1:0]       r_q;
    logic [N-1:0]       r_d;
    logic [CW-1:0]      r_count;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic               r_sign_q;
    logic               r_sign_r;
`endif

    logic [N:0]   w_rs;
    logic [N:0]   w_a;
    logic [N:0]   w_b;
    logic [N:0]   w_res;
    logic         w_cout;
    logic         w_unused_msb;
    logic [N-1:0] w_q_shift;
    logic [N-1:0] w_r_shift;

    assign w_rs = {r_r, r_q[N-1]};

    // The shared subtractor normally trial-subtracts D; the signed build
    // borrows it to form 0 - x for magnitudes and the quotient fix-up.
    always_comb begin
        w_a = w_rs;
        w_b = {1'b0, r_d};
`ifdef SEQ_DIVIDER_SIGNED_EN
        case (r_state)
            S_PREP_A, S_FIX: begin
                w_a = '0;
                w_b = {1'b0, r_q};
            end
            S_PREP_B: begin
                w_a = '0;
                w_b = {1'b0, r_d};
            end
            default: ;
        endcase
`endif
    end

    seq_divider_add_sub #(
        .W (N + 1)
    ) u_add_sub (
        .a        (w_a),
        .b        (w_b),
        .addn_sub (1'b1),
        .result   (w_res),
        .cout     (w_cout)
    );

    // A successful trial subtraction always leaves a value below D, so the
    // top result bit carries no information.
    assign w_unused_msb = w_res[N];
    assign w_q_shift    = {r_q[N-2:0], w_cout};
    assign w_r_shift    = w_cout ? w_res[N-1:0] : w_rs[N-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_r         <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_count     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_d         <= divisor;
                        r_q         <= dividend;
                        r_r         <= '0;
                        r_count     <= '0;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        r_sign_q    <= dividend[N-1] ^ divisor[N-1];
                        r_sign_r    <= dividend[N-1];
`endif
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                            r_state <= S_PREP_A;
`else
                            r_state <= S_RUN;
`endif
                        end
                    end
                end
`ifdef SEQ_DIVIDER_SIGNED_EN
                S_PREP_A: begin
                    if (r_q[N-1]) r_q <= w_res[N-1:0];
                    r_state <= S_PREP_B;
                end
                S_PREP_B: begin
                    if (r_d[N-1]) r_d <= w_res[N-1:0];
                    r_state <= S_RUN;
                end
`endif
                S_RUN: begin
                    r_r     <= w_r_shift;
                    r_q     <= w_q_shift;
                    r_count <= r_count + 1'b1;
                    if (r_count == C_LAST) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                        r_state <= S_FIX;
`else
                        // Results land with done so they are valid in the DONE cycle.
                        quotient  <= w_q_shift;
                        remainder <= w_r_shift;
                        done      <= 1'b1;
                        r_state   <= S_DONE;
`endif
                    end
                end
`ifdef SEQ_DIVIDER_SIGNED_EN
                S_FIX: begin
                    quotient  <= r_sign_q ? w_res[N-1:0] : r_q;
                    remainder <= r_sign_r ? -r_r : r_r;
                    done      <= 1'b1;
                    r_state   <= S_DONE;
                end
`endif
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_seq_divider                                                  |
// | Brief    : Randomised self-checking bench for seq_divider.                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_seq_divider;

    localparam int N = 8;
`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam int LAT = N + 4;
`else
    localparam int LAT = N + 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Arithmetic reference: plain integer division on the operand values.
    function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] q, output logic [N-1:0] r,
                                  output logic z, output int lat);
        if (b == '0) begin
            q = '1; r = a; z = 1'b1; lat = 1;
        end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            longint sa, sb;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = N'(sa / sb);
            r = N'(sa % sb);
`else
            longint unsigned ua, ub;
            ua = longint'(a);
            ub = longint'(b);
            q = N'(ua / ub);
            r = N'(ua % ub);
`endif
            z = 1'b0; lat = LAT;
        end
    endfunction

    // Presents a request and returns just after the accepting edge; the
    // operands are then scrambled to show only captured values matter.
    task automatic start_div(input logic [N-1:0] a, input logic [N-1:0] b);
        if (done) begin
            @(posedge clk); #1;
        end
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = N'($urandom);
        divisor  = N'($urandom);
    endtask

    // lat counts cycles from the accept cycle to the done cycle; -1 on timeout.
    task automatic wait_done(input int cyc0, output int lat);
        lat = cyc0;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_during: got %0h expected 0",
                     {busy, done, quotient, remainder, div_by_zero});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_after: busy=%b done=%b expected 0 0", busy, done);
        end
        checks++;
        if (quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_results: q=%0h r=%0h z=%b expected 0 0 0",
                     quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_directed;
        logic [N-1:0] a[6] = '{8'd100, 8'd42, 8'd42, 8'd200, 8'd156, 8'd128};
        logic [N-1:0] b[6] = '{8'd7, 8'd0, 8'd6, 8'd3, 8'd7, 8'd255};
        logic [N-1:0] eq, er;
        logic         ez;
        int           el, lat;
        for (int i = 0; i < 6; i++) begin
            model(a[i], b[i], eq, er, ez, el);
            start_div(a[i], b[i]);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_busy: got %b expected 1", i, busy);
            end
            wait_done(1, lat);
            checks++;
            if (lat != el) begin
                errors++;
                $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, el);
            end
            checks++;
            if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
                errors++;
                $display("FAIL dir%0d_result %0d/%0d: got q=%0h r=%0h z=%b expected q=%0h r=%0h z=%b",
                         i, a[i], b[i], quotient, remainder, div_by_zero, eq, er, ez);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [N-1:0] eq, er;
        logic         ez;
        int           el, lat;
        start_div(8'd5, 8'd9);
        wait_done(1, lat);
        model(8'd5, 8'd9, eq, er, ez, el);
        checks++;
        if (lat != el || quotient !== eq || remainder !== er) begin
            errors++;
            $display("FAIL b2b_first: got lat=%0d q=%0h r=%0h expected lat=%0d q=%0h r=%0h",
                     lat, quotient, remainder, el, eq, er);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: busy=%b done=%b expected 0 0", busy, done);
        end
        start_div(8'd255, 8'd1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart_busy: got %b expected 1", busy);
        end
        wait_done(1, lat);
        model(8'd255, 8'd1, eq, er, ez, el);
        checks++;
        if (lat != el || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d q=%0h r=%0h expected lat=%0d q=%0h r=%0h",
                     lat, quotient, remainder, el, eq, er);
        end
    endtask

    task automatic test_ignore_start;
        logic [N-1:0] eq, er;
        logic         ez;
        int           el, lat;
        model(8'd200, 8'd3, eq, er, ez, el);
        start_div(8'd200, 8'd3);
        repeat (3) begin
            @(posedge clk); #1;
        end
        dividend = 8'd17;
        divisor  = 8'd5;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        wait_done(5, lat);
        checks++;
        if (lat != el || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
            errors++;
            $display("FAIL ignore_start: got lat=%0d q=%0h r=%0h expected lat=%0d q=%0h r=%0h",
                     lat, quotient, remainder, el, eq, er);
        end
        // The extra pulse must not have been queued behind the first request.
        @(posedge clk); #1;
        repeat (LAT + 2) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL ignore_no_queue: busy=%b done=%b expected 0 0", busy, done);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [N-1:0] eq, er;
        logic         ez;
        int           el, lat;
        bit           seen = 1'b0;
        start_div(8'd200, 8'd3);
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: got %0h expected 0",
                     {busy, done, quotient, remainder, div_by_zero});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * LAT) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid_no_done: got done=1 expected 0");
        end
        model(8'd200, 8'd3, eq, er, ez, el);
        start_div(8'd200, 8'd3);
        wait_done(1, lat);
        checks++;
        if (lat != el || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
            errors++;
            $display("FAIL reset_mid_rerun: got lat=%0d q=%0h r=%0h expected lat=%0d q=%0h r=%0h",
                     lat, quotient, remainder, el, eq, er);
        end
    endtask

    task automatic test_random;
        logic [N-1:0] a, b, eq, er;
        logic         ez;
        int           el, lat;
        for (int i = 0; i < 40; i++) begin
            a = N'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = N'($urandom_range(1, 3));
                default: b = N'($urandom);
            endcase
            model(a, b, eq, er, ez, el);
            start_div(a, b);
            wait_done(1, lat);
            checks++;
            if (lat != el) begin
                errors++;
                $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, el);
            end
            checks++;
            if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
                errors++;
                $display("FAIL rnd%0d_result %0h/%0h: got q=%0h r=%0h z=%b expected q=%0h r=%0h z=%b",
                         i, a, b, quotient, remainder, div_by_zero, eq, er, ez);
            end
        end
        // Results persist through idle.
        repeat (5) begin
            @(posedge clk); #1;
        end
        checks++;
        if (quotient !== eq || remainder !== er || div_by_zero !== ez || done !== 1'b0) begin
            errors++;
            $display("FAIL hold: got q=%0h r=%0h z=%b done=%b expected q=%0h r=%0h z=%b done=0",
                     quotient, remainder, div_by_zero, done, eq, er, ez);
        end
    endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
    task automatic test_signed;
        logic [N-1:0] a[2] = '{8'h9C, 8'h80};
        logic [N-1:0] b[2] = '{8'd7, 8'hFF};
        logic [N-1:0] eq, er;
        logic         ez;
        int           el, lat;
        for (int i = 0; i < 2; i++) begin
            model(a[i], b[i], eq, er, ez, el);
            start_div(a[i], b[i]);
            wait_done(1, lat);
            checks++;
            if (lat != el || quotient !== eq || remainder !== er) begin
                errors++;
                $display("FAIL signed%0d: got lat=%0d q=%0h r=%0h expected lat=%0d q=%0h r=%0h",
                         i, lat, quotient, remainder, el, eq, er);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_random();
`ifdef SEQ_DIVIDER_SIGNED_EN
        test_signed();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
